// File: rtl/cpu_mem_stage_pkg.sv
// Shared definitions for the Moxie memory stage: pipeline-control bit indices,
// access-size encodings and the request/writeback bundles.
package cpu_mem_stage_pkg;

  localparam int PCB_WIDTH = 4;
  localparam int PCB_WA    = 0;  // write register port A
  localparam int PCB_WB    = 1;  // write register port B
  localparam int PCB_RM    = 2;  // read memory
  localparam int PCB_WM    = 3;  // write memory

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_S = 2'b01,
    MEM_SIZE_L = 2'b10
  } mem_size_e;

  // Everything captured from execute while the stage is idle.
  typedef struct packed {
    logic        wa;
    logic        wb;
    logic        rd;
    logic        wr;
    mem_size_e   size;
    logic [3:0]  idx0;
    logic [3:0]  idx1;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        wea;
    logic        web;
    logic [3:0]  idx0;
    logic [3:0]  idx1;
    logic [31:0] res0;
    logic [31:0] res1;
  } wb_t;

endpackage

// File: rtl/cpu_mem_stage_if.sv
// Wishbone data-bus bundle (16-bit data) between the memory stage and data memory.
interface cpu_mem_stage_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] adr;
  logic [15:0]       dat_o;
  logic [15:0]       dat_i;
  logic [1:0]        sel;
  logic              stb;
  logic              cyc;
  logic              we;
  logic              ack;

  modport master (output adr, dat_o, sel, stb, cyc, we, input  dat_i, ack);
  modport slave  (input  adr, dat_o, sel, stb, cyc, we, output dat_i, ack);

endinterface

// File: rtl/cpu_mem_lane.sv
// Byte-lane steering for the 16-bit big-endian bus: select lanes, replicate store
// bytes and extract/zero-extend load data. Purely combinational.
module cpu_mem_lane
  import cpu_mem_stage_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic        addr_lsb_i,
  input  logic        lo_half_i,
  input  logic [31:0] store_data_i,
  input  logic [15:0] hold_hi_i,
  input  logic [15:0] hold_lo_i,
  output logic [1:0]  sel_o,
  output logic [15:0] store_dat_o,
  output logic [31:0] load_data_o
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    sel_o       = 2'b11;
    store_dat_o = store_data_i[15:0];
    load_data_o = {16'h0000, hold_lo_i};
    case (size_i)
      MEM_SIZE_L: begin
        store_dat_o = lo_half_i ? store_data_i[15:0] : store_data_i[31:16];
        load_data_o = {hold_hi_i, hold_lo_i};
      end
      MEM_SIZE_B: begin
        // Even byte sits on the upper lane of a big-endian halfword.
        sel_o       = addr_lsb_i ? 2'b01 : 2'b10;
        store_dat_o = {2{store_data_i[7:0]}};
        load_data_o = {24'h000000, (addr_lsb_i ? hold_lo_i[7:0] : hold_lo_i[15:8])};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_mem_stage.sv
// Moxie memory stage: turns execute's load/store requests into 16-bit Wishbone
// cycles and forwards results to writeback. Optional: MEM_ALIGN_CHECK_EN.
module cpu_mem_stage
  import cpu_mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
  input  logic [3:0]           register0_write_index_i,
  input  logic [3:0]           register1_write_index_i,
  input  logic [31:0]          reg0_result_i,
  input  logic [31:0]          reg1_result_i,
  input  logic [ADDR_W-1:0]    memory_address_i,
  input  logic [31:0]          mem_result_i,
  input  logic [1:0]           mem_size_i,
  output logic                 stall_o,
  cpu_mem_stage_if.master      dmem,
  output logic                 register_wea_o,
  output logic                 register_web_o,
  output logic [3:0]           register0_write_index_o,
  output logic [3:0]           register1_write_index_o,
  output logic [31:0]          reg0_result_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                 align_err_o,
`endif
  output logic [31:0]          reg1_result_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE} state_e;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       hold_hi_q, hold_hi_d;
  logic [15:0]       hold_lo_q, hold_lo_d;
  wb_t               wb_q, wb_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic              align_err_q, align_err_d;
`endif

  logic [ADDR_W-1:0] bus_adr;
  logic [15:0]       bus_dat;
  logic [1:0]        bus_sel;
  logic              bus_stb;
  logic              bus_we;
  logic [1:0]        lane_sel;
  logic [15:0]       lane_dat;
  logic [31:0]       lane_load;

  cpu_mem_lane u_lane (
    .size_i      (req_q.size),
    .addr_lsb_i  (addr_q[0]),
    .lo_half_i   (state_q == S_ACC2),
    .store_data_i(req_q.wdata),
    .hold_hi_i   (hold_hi_q),
    .hold_lo_i   (hold_lo_q),
    .sel_o       (lane_sel),
    .store_dat_o (lane_dat),
    .load_data_o (lane_load)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    hold_hi_d = hold_hi_q;
    hold_lo_d = hold_lo_q;
    wb_d      = '0;
    bus_adr   = '0;
    bus_dat   = '0;
    bus_sel   = '0;
    bus_stb   = 1'b0;
    bus_we    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    align_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        req_d.wa    = pipeline_control_bits_i[PCB_WA];
        req_d.wb    = pipeline_control_bits_i[PCB_WB];
        req_d.wr    = pipeline_control_bits_i[PCB_WM];
        // A store request overrides a simultaneous load request.
        req_d.rd    = pipeline_control_bits_i[PCB_RM] & ~pipeline_control_bits_i[PCB_WM];
        req_d.size  = mem_size_e'(mem_size_i);
        req_d.idx0  = register0_write_index_i;
        req_d.idx1  = register1_write_index_i;
        req_d.r0    = reg0_result_i;
        req_d.r1    = reg1_result_i;
        req_d.wdata = mem_result_i;
        addr_d      = memory_address_i;
        if (req_d.size != MEM_SIZE_B) addr_d[0] = 1'b0;

        if (req_d.rd || req_d.wr) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (req_d.size != MEM_SIZE_B && memory_address_i[0]) begin
            align_err_d = 1'b1;
          end else begin
            state_d = S_ACC1;
          end
`else
          state_d = S_ACC1;
`endif
        end else begin
          wb_d.wea  = req_d.wa;
          wb_d.web  = req_d.wb;
          wb_d.idx0 = req_d.idx0;
          wb_d.idx1 = req_d.idx1;
          wb_d.res0 = req_d.r0;
          wb_d.res1 = req_d.r1;
        end
      end

      S_ACC1, S_ACC2: begin
        bus_stb = 1'b1;
        bus_we  = req_q.wr;
        bus_sel = lane_sel;
        bus_dat = lane_dat;
        bus_adr = (state_q == S_ACC2) ? addr_q + ADDR_W'(2) : addr_q;
        if (dmem.ack) begin
          if (state_q == S_ACC1 && req_q.size == MEM_SIZE_L) begin
            hold_hi_d = dmem.dat_i;
            state_d   = S_ACC2;
          end else begin
            hold_lo_d = dmem.dat_i;
            state_d   = S_DONE;
          end
        end
      end

      S_DONE: begin
        wb_d.wea  = req_q.wa;
        wb_d.web  = req_q.wb;
        wb_d.idx0 = req_q.idx0;
        wb_d.idx1 = req_q.idx1;
        wb_d.res0 = req_q.rd ? lane_load : req_q.r0;
        wb_d.res1 = req_q.r1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      addr_q      <= '0;
      hold_hi_q   <= '0;
      hold_lo_q   <= '0;
      wb_q        <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      hold_hi_q   <= hold_hi_d;
      hold_lo_q   <= hold_lo_d;
      wb_q        <= wb_d;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q <= align_err_d;
`endif
    end
  end

  // Bus strobes decode straight from state so reset drops them immediately.
  assign dmem.adr   = bus_adr;
  assign dmem.dat_o = bus_dat;
  assign dmem.sel   = bus_sel;
  assign dmem.stb   = bus_stb;
  assign dmem.cyc   = bus_stb;
  assign dmem.we    = bus_we;

  assign stall_o                 = (state_q != S_IDLE);
  assign register_wea_o          = wb_q.wea;
  assign register_web_o          = wb_q.web;
  assign register0_write_index_o = wb_q.idx0;
  assign register1_write_index_o = wb_q.idx1;
  assign reg0_result_o           = wb_q.res0;
  assign reg1_result_o           = wb_q.res1;
`ifdef MEM_ALIGN_CHECK_EN
  assign align_err_o             = align_err_q;
`endif

endmodule

// File: tb/tb_cpu_mem_stage.sv
// Scoreboard bench for cpu_mem_stage: a byte-array memory model predicts bus
// cycles and writeback results; a negedge monitor pops and compares them.
module tb_cpu_mem_stage;
  import cpu_mem_stage_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [PCB_WIDTH-1:0] pcb = '0;
  logic [3:0]  idx0 = '0, idx1 = '0;
  logic [31:0] r0 = '0, r1 = '0, addr = '0, wdata = '0;
  logic [1:0]  size = '0;
  logic        stall, wea, web;
  logic [3:0]  oidx0, oidx1;
  logic [31:0] ores0, ores1;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  cpu_mem_stage_if #(.ADDR_W(32)) dmem ();

  cpu_mem_stage #(.ADDR_W(32)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .pipeline_control_bits_i(pcb),
    .register0_write_index_i(idx0),
    .register1_write_index_i(idx1),
    .reg0_result_i          (r0),
    .reg1_result_i          (r1),
    .memory_address_i       (addr),
    .mem_result_i           (wdata),
    .mem_size_i             (size),
    .stall_o                (stall),
    .dmem                   (dmem),
    .register_wea_o         (wea),
    .register_web_o         (web),
    .register0_write_index_o(oidx0),
    .register1_write_index_o(oidx1),
    .reg0_result_o          (ores0),
`ifdef MEM_ALIGN_CHECK_EN
    .align_err_o            (align_err),
`endif
    .reg1_result_o          (ores1)
  );

  typedef struct {logic [31:0] adr; logic we; logic [1:0] sel; logic [15:0] dat;} bus_exp_t;
  typedef struct {logic wea, web; logic [3:0] i0, i1; logic [31:0] d0, d1;} wb_exp_t;
  bus_exp_t bus_q[$];
  wb_exp_t  wbx_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Device memory (the bus slave) and reference memory (the model) start identical.
  logic [7:0] dev_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // Slave with programmable wait states plus output monitor, all mid-cycle.
  int ack_wait = 0;
  int ack_cnt  = 0;
  logic [31:0] base;
  always @(negedge clk_i) begin
    if (dmem.stb) begin
      dmem.ack = (ack_cnt == ack_wait);
      ack_cnt  = dmem.ack ? 0 : ack_cnt + 1;
    end else begin
      dmem.ack = 1'b0;
      ack_cnt  = 0;
    end
    base = {dmem.adr[31:1], 1'b0};
    dmem.dat_i = {dev_rd(base), dev_rd(base + 32'd1)};
    check("cyc_eq_stb", 64'(dmem.cyc), 64'(dmem.stb));
    if (dmem.stb && dmem.ack) begin
      if (bus_q.size() == 0) begin
        check("bus_unexpected", 64'(dmem.stb), 64'd0);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        check("bus_adr", 64'(dmem.adr), 64'(e.adr));
        check("bus_we",  64'(dmem.we),  64'(e.we));
        check("bus_sel", 64'(dmem.sel), 64'(e.sel));
        if (e.we) check("bus_dat", 64'(dmem.dat_o), 64'(e.dat));
      end
      if (dmem.we) begin
        if (dmem.sel[1]) dev_mem[base] = dmem.dat_o[15:8];
        if (dmem.sel[0]) dev_mem[base + 32'd1] = dmem.dat_o[7:0];
      end
    end
    if (wea || web) begin
      if (wbx_q.size() == 0) begin
        check("wb_unexpected", 64'({wea, web}), 64'd0);
      end else begin
        wb_exp_t w;
        w = wbx_q.pop_front();
        check("wb_wea",  64'(wea),   64'(w.wea));
        check("wb_web",  64'(web),   64'(w.web));
        check("wb_idx0", 64'(oidx0), 64'(w.i0));
        check("wb_idx1", 64'(oidx1), 64'(w.i1));
        check("wb_res0", 64'(ores0), 64'(w.d0));
        check("wb_res1", 64'(ores1), 64'(w.d1));
      end
    end
  end

  task automatic junk_inputs();
    pcb = PCB_WIDTH'($urandom); addr = $urandom; wdata = $urandom; size = 2'($urandom);
    r0 = $urandom; r1 = $urandom; idx0 = 4'($urandom); idx1 = 4'($urandom);
  endtask

  // sz: 0=byte 1=short 2=long. Predicts bus cycles and writeback from the rules, then runs it.
  task automatic issue(input logic wa, input logic wb, input logic rm, input logic wm,
                       input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] i0, input logic [3:0] i1,
                       input logic [31:0] d0, input logic [31:0] d1, input int wait_n);
    logic        mem_op, misal;
    logic [31:0] a0, ld;
    int          halves, n_stall, n_stb;
    mem_op = rm | wm;
    misal  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal  = mem_op && (sz != 2'd0) && a[0];
`endif
    a0     = (sz == 2'd0) ? a : {a[31:1], 1'b0};
    halves = (sz == 2'd2) ? 2 : 1;
    ld     = d0;
    if (mem_op && !misal) begin
      if (sz == 2'd2) begin
        bus_q.push_back('{a0,          wm, 2'b11, wd[31:16]});
        bus_q.push_back('{a0 + 32'd2,  wm, 2'b11, wd[15:0]});
      end else if (sz == 2'd1) begin
        bus_q.push_back('{a0, wm, 2'b11, wd[15:0]});
      end else begin
        bus_q.push_back('{a, wm, (a[0] ? 2'b01 : 2'b10), {wd[7:0], wd[7:0]}});
      end
      if (wm) begin
        for (int k = 0; k < halves * 2; k++) begin
          if (sz == 2'd0) begin
            if (k == 0) ref_mem[a] = wd[7:0];
          end else begin
            ref_mem[a0 + 32'(k)] = wd[8*(halves*2-1-k) +: 8];
          end
        end
      end else begin
        if (sz == 2'd2)
          ld = {ref_rd(a0), ref_rd(a0 + 32'd1), ref_rd(a0 + 32'd2), ref_rd(a0 + 32'd3)};
        else if (sz == 2'd1) ld = {16'h0, ref_rd(a0), ref_rd(a0 + 32'd1)};
        else                 ld = {24'h0, ref_rd(a)};
      end
    end
    if ((wa || wb) && !misal) wbx_q.push_back('{wa, wb, i0, i1, ld, d1});

    ack_wait = wait_n;
    pcb = '0; pcb[PCB_WA] = wa; pcb[PCB_WB] = wb; pcb[PCB_RM] = rm; pcb[PCB_WM] = wm;
    size = sz; addr = a; wdata = wd; idx0 = i0; idx1 = i1; r0 = d0; r1 = d1;
    @(posedge clk_i); #1;
`ifdef MEM_ALIGN_CHECK_EN
    check("align_err", 64'(align_err), 64'(misal));
`endif
    n_stall = 0;
    n_stb   = 0;
    while (stall && n_stall < 100) begin
      n_stall++;
      if (dmem.stb) n_stb++;
      junk_inputs();
      @(posedge clk_i); #1;
    end
    pcb = '0;
    check("stall_cycles", 64'(n_stall), (mem_op && !misal) ? 64'(halves * (wait_n + 1) + 1) : 64'd0);
    check("stb_cycles",   64'(n_stb),   (mem_op && !misal) ? 64'(halves * (wait_n + 1)) : 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_bus",   64'({dmem.stb, dmem.cyc, dmem.we, dmem.sel}), 64'd0);
    check("rst_adr",   64'(dmem.adr), 64'd0);
    check("rst_dat",   64'(dmem.dat_o), 64'd0);
    check("rst_wb",    64'({wea, web, oidx0, oidx1}), 64'd0);
    check("rst_res",   {ores0, ores1}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Register-only path and a plain bubble.
    issue(1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 4'd3, 4'd0, 32'h1234, 32'h0, 0);
    check("t1_wea",  64'(wea),   64'd1);
    check("t1_idx",  64'(oidx0), 64'd3);
    check("t1_res",  64'(ores0), 64'h1234);
    check("t1_stb",  64'(dmem.stb), 64'd0);
    issue(0, 0, 0, 0, 2'd2, 32'h40, 32'h0, 4'd1, 4'd2, 32'h9, 32'h8, 0);
    check("bubble_wea", 64'({wea, web}), 64'd0);

    issue(0, 0, 0, 1, 2'd2, 32'h100, 32'hDEADBEEF, 4'd0, 4'd0, 32'h0, 32'h0, 0);

    dev_mem[32'h200] = 8'hAB; dev_mem[32'h201] = 8'h5C;
    ref_mem[32'h200] = 8'hAB; ref_mem[32'h201] = 8'h5C;
    issue(1, 0, 1, 0, 2'd0, 32'h201, 32'h0, 4'd5, 4'd6, 32'hFFFF, 32'h77, 0);
    check("t3_wea", 64'(wea),   64'd1);
    check("t3_res", 64'(ores0), 64'h5C);

    issue(1, 1, 1, 0, 2'd2, 32'h300, 32'h0, 4'd7, 4'd8, 32'h1, 32'h2, 3);

    // Reset while the second half of a long load is outstanding.
    ack_wait = 0;
    bus_q.push_back('{32'h500, 1'b0, 2'b11, 16'h0});
    pcb = '0; pcb[PCB_WA] = 1'b1; pcb[PCB_RM] = 1'b1; size = 2'd2; addr = 32'h500;
    @(posedge clk_i); #1; pcb = '0;
    @(posedge clk_i); #1;
    check("t5_in_acc2", 64'({dmem.stb, dmem.adr}), {31'h0, 1'b1, 32'h502});
    ack_wait = 50;
    #2 rst_i = 1'b1;
    #1;
    check("t5_rst_bus", 64'({dmem.stb, dmem.cyc, stall, wea}), 64'd0);
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("t5_idle", 64'(stall), 64'd0);

    issue(1, 0, 1, 0, 2'd1, 32'h401, 32'h0, 4'd9, 4'd1, 32'h3, 32'h4, 0);
    issue(0, 0, 0, 1, 2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 4'd0, 4'd0, 32'h0, 32'h0, 1);
    issue(1, 0, 1, 0, 2'd2, 32'hFFFF_FFFE, 32'h0, 4'd2, 4'd3, 32'h0, 32'h0, 0);
    issue(1, 1, 1, 1, 2'd1, 32'h600, 32'h0000_4321, 4'd4, 4'd5, 32'h55, 32'h66, 2);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic        rm, wm;
      int          t;
      case ($urandom_range(0, 3))
        0:       a = 32'h1000 + 32'($urandom_range(0, 15));
        1:       a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        2:       a = 32'h2000 + 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      t  = $urandom_range(0, 9);
      rm = (t >= 2 && t <= 5) || t == 9;
      wm = (t >= 6);
      issue(1'($urandom), 1'($urandom), rm, wm, 2'($urandom_range(0, 2)), a, $urandom,
            4'($urandom), 4'($urandom), $urandom, $urandom, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("bus_queue_empty", 64'(bus_q.size()), 64'd0);
    check("wb_queue_empty",  64'(wbx_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
